// File: rtl/pipelined_data_memory.sv
// MEM-stage data RAM: byte-lane stores, extended loads, fault detection, zero-init FSM.
// Latency READ_LATENCY cycles per accepted request; req_ready is low only while INIT runs.
module pipelined_data_memory #(
    parameter int DEPTH         = 1024,
    parameter int READ_LATENCY  = 1,
    parameter int INIT_ON_RESET = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_fault,
    output logic        rsp_is_store,
    output logic        init_done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);
    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    typedef struct packed {
        logic        vld;
        logic        fault;
        logic        store;
        logic [31:0] data;
    } rsp_t;

    logic [0:0]    state;
    logic [AW-1:0] init_cnt;
    logic [31:0]   mem [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == LAST_WORD) begin
                state     <= ST_READY;
                init_done <= 1'b1;
            end
        end else begin
            init_done <= 1'b1;
        end
    end

    assign req_ready = (state == ST_READY) && !reset;

    logic          accept;
    logic [1:0]    lane;
    logic [1:0]    size;
    logic [AW-1:0] idx;
    logic          out_of_range, bad_func3, misaligned, fault;
    logic          init_we, store_we;
    logic [3:0]    be;
    logic [31:0]   wdat;

    assign accept       = req_valid && req_ready;
    assign lane         = req_addr[1:0];
    assign size         = req_func3[1:0];
    assign idx          = req_addr[AW+1:2];
    assign out_of_range = |req_addr[31:AW+2];
    // Loads reject 011/110/111; stores accept only 000/001/010.
    assign bad_func3    = req_write ? (req_func3 > 3'd2)
                                    : ((req_func3[1:0] == 2'b11) || (req_func3[2:1] == 2'b11));
    assign misaligned   = ((size == 2'b01) && lane[0]) || ((size == 2'b10) && (lane != 2'b00));
    assign fault        = bad_func3 || misaligned || out_of_range;
    assign init_we      = (state == ST_INIT) && !reset;
    assign store_we     = accept && req_write && !fault;

    always_comb begin
        be   = 4'b1111;
        wdat = req_wdata;
        case (size)
            2'b00: begin
                be   = 4'b0001 << lane;
                wdat = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be   = 4'b0011 << lane;
                wdat = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    logic [31:0] rd_word;

    always_ff @(posedge clock) begin
        if (init_we) begin
            mem[init_cnt] <= '0;
        end else if (store_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdat[8*b +: 8];
            end
        end
        if (accept) rd_word <= mem[idx];
    end

    logic       s1_vld, s1_fault, s1_store;
    logic [2:0] s1_func3;
    logic [1:0] s1_lane;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_vld   <= 1'b0;
            s1_fault <= 1'b0;
            s1_store <= 1'b0;
            s1_func3 <= '0;
            s1_lane  <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_fault <= fault;
                s1_store <= req_write;
                s1_func3 <= req_func3;
                s1_lane  <= lane;
            end
        end
    end

    logic [31:0] shifted;
    logic [31:0] load_data;

    always_comb begin
        shifted   = rd_word >> {s1_lane, 3'b000};
        load_data = '0;
        if (s1_vld && !s1_fault && !s1_store) begin
            case (s1_func3)
                3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
                3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
                3'b010:  load_data = shifted;
                3'b100:  load_data = {24'h0, shifted[7:0]};
                3'b101:  load_data = {16'h0, shifted[15:0]};
                default: load_data = '0;
            endcase
        end
    end

    rsp_t s1_rsp;
    assign s1_rsp = '{vld: s1_vld, fault: s1_vld && s1_fault, store: s1_vld && s1_store, data: load_data};

    generate
        if (READ_LATENCY == 1) begin : g_direct
            assign rsp_valid    = s1_rsp.vld;
            assign rsp_fault    = s1_rsp.fault;
            assign rsp_is_store = s1_rsp.store;
            assign rsp_data     = s1_rsp.data;
        end else begin : g_pipe
            rsp_t pipe [READ_LATENCY-1];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < READ_LATENCY - 1; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= s1_rsp;
                    for (int i = 1; i < READ_LATENCY - 1; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign rsp_valid    = pipe[READ_LATENCY-2].vld;
            assign rsp_fault    = pipe[READ_LATENCY-2].fault;
            assign rsp_is_store = pipe[READ_LATENCY-2].store;
            assign rsp_data     = pipe[READ_LATENCY-2].data;
        end
    endgenerate
endmodule

// File: tb/tb_pipelined_data_memory.sv
// Bench for pipelined_data_memory: directed vector table, reset/INIT sequences, random traffic vs byte-array model.
module tb_pipelined_data_memory;
    localparam int DEPTH = 1024;
    localparam int RL    = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_func3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_fault, rsp_is_store, init_done;
    logic [31:0] rsp_data;

    always #5 clock = ~clock;

    pipelined_data_memory #(
        .DEPTH(DEPTH), .READ_LATENCY(RL), .INIT_ON_RESET(1)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
        .rsp_is_store(rsp_is_store), .init_done(init_done)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        fault;
        logic        store;
    } exp_t;

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] ed;
        logic        ef;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t expq[$];
    vec_t tbl[$];
    logic [7:0] mbytes [DEPTH*4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Architectural model: little-endian byte memory, sizes 1/2/4 bytes.
    task automatic model_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d, output logic [31:0] data, output logic fault);
        int  n;
        int  ia;
        logic illegal, mis, oor;
        n       = 1 << f3[1:0];
        illegal = w ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis     = (f3[1:0] == 2'd1 && (a % 2) != 0) || (f3[1:0] == 2'd2 && (a % 4) != 0);
        oor     = a >= 32'(DEPTH * 4);
        fault   = illegal || mis || oor;
        data    = '0;
        if (!fault) begin
            ia = int'(a);
            if (w) begin
                for (int k = 0; k < n; k++) mbytes[ia+k] = d[8*k +: 8];
            end else begin
                case (f3)
                    3'd0: data = {{24{mbytes[ia][7]}}, mbytes[ia]};
                    3'd4: data = {24'h0, mbytes[ia]};
                    3'd1: data = {{16{mbytes[ia+1][7]}}, mbytes[ia+1], mbytes[ia]};
                    3'd5: data = {16'h0, mbytes[ia+1], mbytes[ia]};
                    default: data = {mbytes[ia+3], mbytes[ia+2], mbytes[ia+1], mbytes[ia]};
                endcase
            end
        end
    endtask

    task automatic check_rsp();
        exp_t e;
        if (expq.size() > 0 && expq[0].due == cyc) begin
            e = expq.pop_front();
            check("rsp_valid", {31'h0, rsp_valid}, 32'h1);
            check("rsp_data", rsp_data, e.data);
            check("rsp_fault", {31'h0, rsp_fault}, {31'h0, e.fault});
            check("rsp_is_store", {31'h0, rsp_is_store}, {31'h0, e.store});
        end else begin
            check("rsp_valid_idle", {31'h0, rsp_valid}, 32'h0);
        end
    endtask

    // Called at a negedge: check this cycle's response, drive the next request, advance one clock.
    task automatic cycle(input logic v, input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic use_exp, input logic [31:0] ed, input logic ef);
        exp_t        e;
        logic [31:0] md;
        logic        mf;
        check_rsp();
        req_valid = v;
        req_write = w;
        req_func3 = f3;
        req_addr  = a;
        req_wdata = d;
        if (v) begin
            check("req_ready", {31'h0, req_ready}, 32'h1);
            model_req(w, f3, a, d, md, mf);
            e.due   = cyc + RL;
            e.data  = use_exp ? ed : md;
            e.fault = use_exp ? ef : mf;
            e.store = w;
            expq.push_back(e);
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < RL + 2; i++) cycle(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("drain_empty", 32'(expq.size()), 32'h0);
    endtask

    task automatic reset_and_init();
        int n;
        reset     = 1'b1;
        req_valid = 1'b0;
        expq.delete();
        for (int i = 0; i < DEPTH * 4; i++) mbytes[i] = 8'h0;
        #1;
        check("reset_req_ready", {31'h0, req_ready}, 32'h0);
        check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("reset_rsp_data", rsp_data, 32'h0);
        check("reset_rsp_fault", {31'h0, rsp_fault}, 32'h0);
        check("reset_rsp_is_store", {31'h0, rsp_is_store}, 32'h0);
        check("reset_init_done", {31'h0, init_done}, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        n = 0;
        while (!req_ready && n < 2 * DEPTH) begin
            if (n < RL + 2) check("rsp_after_reset", {31'h0, rsp_valid}, 32'h0);
            if (n == 1) check("init_done_during_init", {31'h0, init_done}, 32'h0);
            @(posedge clock);
            @(negedge clock);
            n++;
            cyc++;
        end
        check("init_cycles", 32'(n), 32'(DEPTH));
        check("init_done_after", {31'h0, init_done}, 32'h1);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_func3 = 3'd0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        @(negedge clock);

        tbl.push_back('{1'b1, 3'd2, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 3'd0, 32'h11,       32'h00000055, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 3'd2, 32'h10,       32'h0,        32'hDEAD55EF, 1'b0});
        tbl.push_back('{1'b0, 3'd0, 32'h13,       32'h0,        32'hFFFFFFDE, 1'b0});
        tbl.push_back('{1'b0, 3'd4, 32'h13,       32'h0,        32'h000000DE, 1'b0});
        tbl.push_back('{1'b1, 3'd1, 32'h22,       32'h00008001, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 3'd1, 32'h22,       32'h0,        32'hFFFF8001, 1'b0});
        tbl.push_back('{1'b0, 3'd5, 32'h22,       32'h0,        32'h00008001, 1'b0});
        tbl.push_back('{1'b0, 3'd2, 32'h20,       32'h0,        32'h80010000, 1'b0});
        tbl.push_back('{1'b0, 3'd2, 32'h21,       32'h0,        32'h0,        1'b1});
        tbl.push_back('{1'b1, 3'd1, 32'h23,       32'h00001234, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 3'd2, 32'h1000,     32'h0,        32'h0,        1'b1});
        tbl.push_back('{1'b0, 3'd2, 32'h20,       32'h0,        32'h80010000, 1'b0});
        tbl.push_back('{1'b0, 3'd2, 32'h0,        32'h0,        32'h0,        1'b0});
        tbl.push_back('{1'b1, 3'd0, 32'h17,       32'h000001AB, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 3'd2, 32'h14,       32'h0,        32'hAB000000, 1'b0});
        tbl.push_back('{1'b0, 3'd0, 32'h17,       32'h0,        32'hFFFFFFAB, 1'b0});
        tbl.push_back('{1'b0, 3'd3, 32'h14,       32'h0,        32'h0,        1'b1});
        tbl.push_back('{1'b0, 3'd6, 32'h14,       32'h0,        32'h0,        1'b1});
        tbl.push_back('{1'b1, 3'd3, 32'h14,       32'hFFFFFFFF, 32'h0,        1'b1});
        tbl.push_back('{1'b1, 3'd4, 32'h14,       32'hFFFFFFFF, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 3'd2, 32'h14,       32'h0,        32'hAB000000, 1'b0});
        tbl.push_back('{1'b1, 3'd2, 32'hFFC,      32'h12345678, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 3'd2, 32'hFFC,      32'h0,        32'h12345678, 1'b0});
        tbl.push_back('{1'b0, 3'd1, 32'h80000000, 32'h0,        32'h0,        1'b1});

        reset_and_init();
        foreach (tbl[i]) cycle(1'b1, tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].d, 1'b1, tbl[i].ed, tbl[i].ef);
        drain();

        // Random traffic, mostly in a small window so loads hit earlier stores.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = (($urandom_range(0, 15)) == 0) ? $urandom : 32'($urandom_range(0, 63));
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  a, $urandom, 1'b0, 32'h0, 1'b0);
        end
        drain();

        // Two loads in flight when reset hits: both responses must vanish.
        cycle(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 3'd2, 32'h14, 32'h0, 1'b0, 32'h0, 1'b0);
        req_valid = 1'b0;
        reset_and_init();

        // Reset partway through INIT must restart the sweep from word 0.
        cycle(1'b1, 1'b1, 3'd2, 32'hFA0, 32'h11223344, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 3'd2, 32'h0,   32'hA5A5A5A5, 1'b0, 32'h0, 1'b0);
        drain();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (500) @(negedge clock);
        check("ready_mid_init", {31'h0, req_ready}, 32'h0);
        reset_and_init();
        cycle(1'b1, 1'b0, 3'd2, 32'hFA0, 32'h0, 1'b1, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 3'd2, 32'h0,   32'h0, 1'b1, 32'h0, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipelined_data_memory.md
Name: pipelined_data_memory

Overview:
- Next-generation data memory for the MEM stage.
- Word-organised, byte-addressed RAM with:
  - true byte-lane sub-word stores (SB/SH merge into the existing word without clobbering other bytes);
  - lane-shifted sub-word loads;
  - misalignment, out-of-range and illegal-func3 fault detection;
  - parametrised depth and read latency;
  - a valid/ready request handshake;
  - a hardware zero-init state machine after reset.
- Sits between the EX/MEM pipeline register and the writeback mux.
- The hazard unit stalls the pipeline on req_ready low.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, 16..65536.
- READ_LATENCY, 1, cycles from request acceptance to response; legal range 1..4.
- INIT_ON_RESET, 1, 1 = zero every word after reset via the INIT FSM; 0 = skip INIT, contents undefined.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present this cycle.
- req_ready  output  1  block can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_func3  input  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; low bytes used for SB/SH.
- rsp_valid  output  1  response valid (one-cycle pulse per accepted request).
- rsp_data  output  32  load result, extended per func3; 0 for stores and faults.
- rsp_fault  output  1  request faulted; no memory side effect occurred.
- rsp_is_store  output  1  response belongs to a store.
- init_done  output  1  INIT complete; stays high until next reset.

Behaviour:
- Reset (async, active-high): every output 0; FSM to INIT (or READY if INIT_ON_RESET=0); all response pipeline stages invalidated.
  - RAM contents are not reset asynchronously.
  - Reset mid-INIT or mid-request drops all in-flight responses and restarts INIT from word 0.
- FSM:
  - INIT: counter increments 0..DEPTH-1, writing 32'h0 to one word per cycle. After word DEPTH-1 is written, go to READY and set init_done. INIT lasts exactly DEPTH cycles after reset deassertion. req_ready=0 throughout.
  - READY: req_ready=1 every cycle. A request is accepted when req_valid && req_ready. No other states.
- Address decode:
  - word index = req_addr[log2(DEPTH)+1:2]; lane = req_addr[1:0].
  - Out-of-range fault: any req_addr bit above log2(DEPTH)+1 set.
- Fault rules (fault → no write; rsp_data=0):
  - Halfword access with lane[0]=1.
  - Word access with lane≠0.
  - Load func3 in {011,110,111}.
  - Store func3 not in {000,001,010}.
  - Out-of-range address.
- Stores:
  - Byte enables: SB → 1<<lane; SH → 4'b0011<<lane; SW → 4'b1111.
  - Data replicated across lanes (SB: {4{wdata[7:0]}}, SH: {2{wdata[15:0]}}).
  - Only enabled bytes written, on the accepting clock edge.
  - rsp_valid with rsp_is_store=1 and rsp_data=0 after READ_LATENCY cycles.
- Loads:
  - Word read synchronously on the accepting edge.
  - Selected byte/halfword shifted down by lane×8.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Result traverses READ_LATENCY-1 further register stages.
  - rsp_valid is high exactly READ_LATENCY cycles after the acceptance edge.
- Ordering:
  - Fully pipelined, one request per cycle; responses in order.
  - A store accepted in cycle N is visible to a load accepted in cycle N+1 or later (read-after-write). No same-cycle conflict exists because at most one request is accepted per cycle.
- Wrap-around: none; addresses beyond DEPTH fault rather than alias.

Test Plan:
- Reset, DEPTH=1024, INIT_ON_RESET=1 → req_ready=0 for 1024 cycles, then init_done=1 and req_ready=1; LW 0x0 returns 0.
- SW 0x10=0xDEADBEEF, then SB 0x11=0x55, then LW 0x10 → rsp_data=0xDEAD55EF; LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE.
- SH 0x22=0x8001, then LH 0x22 → 0xFFFF8001; LHU 0x22 → 0x00008001; LW 0x20 → 0x80010000.
- LW 0x21, SH 0x23, LW 0x1000 (out of range) → each rsp_fault=1, rsp_data=0; a following LW 0x20 shows the word unchanged.
- READ_LATENCY=3, back-to-back loads on cycles 0..3 → rsp_valid on cycles 3..6, in order, with correct data.
- Assert reset at INIT word 500, release → INIT restarts at word 0 and lasts 1024 cycles. Assert reset with two loads in flight → no rsp_valid after release.
